// File: rtl/timer_pkg.sv
// Shared definitions for the region timer: register offsets, CTRL bit
// positions, the CTRL field layout and the count FSM state encoding.
package timer_pkg;

    localparam logic [31:0] TMR_CTRL     = 32'h00;
    localparam logic [31:0] TMR_PRESCALE = 32'h04;
    localparam logic [31:0] TMR_LOAD     = 32'h08;
    localparam logic [31:0] TMR_COUNT    = 32'h0C;
    localparam logic [31:0] TMR_STATUS   = 32'h10;
    localparam logic [31:0] TMR_END      = 32'h14;

    localparam int CTRL_EN          = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_IRQ_EN      = 2;

    localparam int STATUS_EXPIRED   = 0;

    typedef struct packed {
        logic irq_en;
        logic auto_reload;
        logic en;
    } ctrl_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Word index (addr[4:2]) of a byte offset.
    function automatic logic [2:0] word_idx(input logic [31:0] offs);
        return offs[4:2];
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescale counter for the region timer.
// Counts 0..psc while en is high and raises tick for one cycle on the
// cycle the count sits at psc (so one tick every psc+1 clocks).
// Ports:
//   clk   in   system clock
//   rst_n in   synchronous active-low reset
//   en    in   count enable; counter is held at 0 while low
//   clr   in   restart the prescale period from 0
//   psc   in   terminal value of the prescale count
//   tick  out  one-cycle pulse at the end of each prescale period
module timer_prescaler #(
    parameter int PSC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [PSC_W-1:0] psc,
    output logic             tick
);

    logic [PSC_W-1:0] cnt_q;

    assign tick = en & (cnt_q == psc);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr || !en || (cnt_q == psc)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + PSC_W'(1);
        end
    end

endmodule

// File: rtl/region_timer.sv
// Memory-mapped prescaled down-counting timer on one chipset region port.
// One-shot or auto-reload, with a sticky EXPIRED flag and optional irq.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   ST_IDLE | CTRL.EN=0, prescaler held, COUNT frozen
//   ST_RUN  | CTRL.EN=1, COUNT decrements on every prescale tick
//
// Register map (byte offsets, decode on addr[4:2], addr>=0x14 unmapped):
//   0x00 CTRL [0]EN [1]AUTO_RELOAD [2]IRQ_EN
//   0x04 PRESCALE, 0x08 LOAD, 0x0C COUNT, 0x10 STATUS [0]EXPIRED (W1C)
// Ports:
//   clk   in   system clock
//   rst_n in   synchronous active-low reset
//   we    in   write enable
//   addr  in   region-relative byte offset
//   wd    in   write data
//   rd    out  read data, combinational from addr
//   irq   out  level interrupt
// Build option: define REGION_TIMER_IRQ_EN to drive irq from
// EXPIRED & CTRL.IRQ_EN; otherwise irq is tied low.
module region_timer #(
    parameter int PSC_W = 16,
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq
);

    import timer_pkg::*;

    state_t           state;
    logic             auto_reload_q;
    logic             irq_en_q;
    logic [PSC_W-1:0] psc_q;
    logic [CNT_W-1:0] load_q;
    logic [CNT_W-1:0] count_q;
    logic             expired_q;

    logic       in_range;
    logic [2:0] idx;
    logic       wr_ctrl, wr_psc, wr_load, wr_count, wr_status;
    logic       run;
    logic       tick;
    logic       psc_clr;
    ctrl_t      ctrl_v;

    assign in_range  = (addr < TMR_END);
    assign idx       = addr[4:2];
    assign wr_ctrl   = we & in_range & (idx == word_idx(TMR_CTRL));
    assign wr_psc    = we & in_range & (idx == word_idx(TMR_PRESCALE));
    assign wr_load   = we & in_range & (idx == word_idx(TMR_LOAD));
    assign wr_count  = we & in_range & (idx == word_idx(TMR_COUNT));
    assign wr_status = we & in_range & (idx == word_idx(TMR_STATUS));

    assign run = (state == ST_RUN);

    // A COUNT write restarts the prescale period so the new value gets a
    // full period before its first decrement.
    assign psc_clr = wr_psc | wr_count | (wr_ctrl & wd[CTRL_EN] & ~run);

    timer_prescaler #(.PSC_W(PSC_W)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (run),
        .clr   (psc_clr),
        .psc   (psc_q),
        .tick  (tick)
    );

    // Ordering inside the else-branch sets priorities: the W1C clear comes
    // before the expiry set (set wins), while CTRL/COUNT writes come after
    // the tick update (writes win over the one-shot stop and the decrement).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            auto_reload_q <= 1'b0;
            irq_en_q      <= 1'b0;
            psc_q         <= '0;
            load_q        <= '0;
            count_q       <= '0;
            expired_q     <= 1'b0;
        end else begin
            if (wr_status && wd[STATUS_EXPIRED]) begin
                expired_q <= 1'b0;
            end

            if (run && tick) begin
                if (count_q != '0) begin
                    count_q <= count_q - CNT_W'(1);
                end else begin
                    expired_q <= 1'b1;
                    if (auto_reload_q) begin
                        count_q <= load_q;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            end

            if (wr_ctrl) begin
                state         <= wd[CTRL_EN] ? ST_RUN : ST_IDLE;
                auto_reload_q <= wd[CTRL_AUTO_RELOAD];
                irq_en_q      <= wd[CTRL_IRQ_EN];
            end
            if (wr_psc) begin
                psc_q <= wd[PSC_W-1:0];
            end
            if (wr_load) begin
                load_q <= wd[CNT_W-1:0];
            end
            if (wr_count) begin
                count_q <= wd[CNT_W-1:0];
            end
        end
    end

    assign ctrl_v = '{irq_en: irq_en_q, auto_reload: auto_reload_q, en: run};

    always_comb begin
        rd = '0;
        if (in_range) begin
            case (idx)
                word_idx(TMR_CTRL):     rd[2:0]       = ctrl_v;
                word_idx(TMR_PRESCALE): rd[PSC_W-1:0] = psc_q;
                word_idx(TMR_LOAD):     rd[CNT_W-1:0] = load_q;
                word_idx(TMR_COUNT):    rd[CNT_W-1:0] = count_q;
                word_idx(TMR_STATUS):   rd[STATUS_EXPIRED] = expired_q;
                default:                rd = '0;
            endcase
        end
    end

`ifdef REGION_TIMER_IRQ_EN
    assign irq = expired_q & irq_en_q;
`else
    assign irq = 1'b0;
`endif

endmodule
